// File: rtl/bus_xcvr_pkg.sv
// bus_xcvr_pkg: shared states, direction encodings and sizing helper for the transceiver sequencer
package bus_xcvr_pkg;
  typedef enum logic [1:0] {IDLE, TURN, ENABLE, HOLD} xcvr_state_t;
  localparam logic DIR_A_TO_B = 1'b1;
  localparam logic DIR_B_TO_A = 1'b0;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/bus_xcvr_ctrl_timer.sv
// xcvr_phase_timer: loadable down-counter that saturates at zero and flags it
module xcvr_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - W'(1);
  assign zero = count == '0;
endmodule

// File: rtl/bus_xcvr_ctrl.sv
// bus_xcvr_ctrl: dir/nOE sequencer for a 74245-style transceiver with turnaround dead time.
// Define BUS_XCVR_CTRL_LOG_EN for transaction logging and simulation-time invariant checks.
module bus_xcvr_ctrl
  import bus_xcvr_pkg::*;
#(
  parameter int TURN_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       xcvr_dir,
  output logic       xcvr_nOE,
  inout  wire  [7:0] a_bus
);
  localparam int CW = $clog2(max3(TURN_CYCLES, SETTLE_CYCLES, HOLD_CYCLES) + 1);
  if (TURN_CYCLES < 1 || SETTLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
    $fatal(1, "bus_xcvr_ctrl: all cycle parameters must be >= 1");
  end
  xcvr_state_t state, state_nx;
  logic wr, dir, load, zero, accept, a_drive, last_read;
  logic [7:0] wdata;
  logic [CW-1:0] load_val;
  assign accept    = req_valid && req_ready;
  assign req_ready = state == IDLE && !reset;
  assign busy      = ~req_ready;
  assign xcvr_dir  = dir;
  assign xcvr_nOE  = state != ENABLE;
  assign a_drive   = wr && (state == ENABLE || state == HOLD);
  assign a_bus     = a_drive ? wdata : 8'hzz;
  assign last_read = state == ENABLE && zero && !wr;
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE:    if (accept) begin state_nx = dir != req_write ? TURN : ENABLE; load = 1'b1; end
      TURN:    if (zero) begin state_nx = ENABLE; load = 1'b1; end
      ENABLE:  if (zero) begin state_nx = HOLD; load = 1'b1; end
      default: if (zero) state_nx = IDLE;
    endcase
    load_val = state_nx == TURN   ? CW'(TURN_CYCLES - 1) :
               state_nx == ENABLE ? CW'(SETTLE_CYCLES - 1) : CW'(HOLD_CYCLES - 1);
  end
  xcvr_phase_timer #(.W(CW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      dir       <= DIR_B_TO_A;
      wr        <= 1'b0;
      wdata     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      state     <= state_nx;
      rsp_valid <= last_read;
      if (accept) begin
        wr    <= req_write;
        wdata <= req_data;
      end
      if (state == IDLE && state_nx == TURN) dir <= req_write ? DIR_A_TO_B : DIR_B_TO_A;
      if (last_read) rsp_data <= a_bus;
    end
`ifdef BUS_XCVR_CTRL_LOG_EN
  logic prev_dir, prev_noe;
  always @(posedge clk) begin
    if (accept) $display("%0t bus_xcvr_ctrl accept dir=%0b data=%02h", $time, req_write, req_data);
    if (rsp_valid) $display("%0t bus_xcvr_ctrl rsp data=%02h", $time, rsp_data);
    if (!reset) begin
      if (!xcvr_nOE && !prev_noe && xcvr_dir != prev_dir) $error("bus_xcvr_ctrl: dir changed while enabled");
      if (!xcvr_nOE && prev_noe && xcvr_dir != prev_dir) $error("bus_xcvr_ctrl: enable coincided with dir change");
      if (a_drive && xcvr_dir == DIR_B_TO_A) $error("bus_xcvr_ctrl: a_bus driven while dir=B->A");
    end
    prev_dir <= xcvr_dir;
    prev_noe <= xcvr_nOE;
  end
`else
`endif
endmodule
